// File: rtl/test_pattern_gen_pkg.sv
// Shared types and constants for the video test pattern generator.
package test_pattern_gen_pkg;

  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned X_W      = 12;
  localparam int unsigned Y_W      = 11;
  localparam int unsigned BAR_W    = 3;

  // {hsync, vsync, de}: both syncs idle high, no active pixel
  localparam logic [2:0] SYNCO_RST = 3'b110;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_GRID  = 2'd3
  } pattern_e;

  typedef struct packed {
    pattern_e       pat;
    logic [X_W-1:0] h_size;
    logic [Y_W-1:0] v_size;
  } frame_cfg_t;

  // Bar colours as {R,G,B} on/off masks, full scale when set
  function automatic logic [2:0] bar_mask(input logic [BAR_W-1:0] idx);
    case (idx)
      3'd0:    bar_mask = 3'b111;
      3'd1:    bar_mask = 3'b110;
      3'd2:    bar_mask = 3'b011;
      3'd3:    bar_mask = 3'b010;
      3'd4:    bar_mask = 3'b101;
      3'd5:    bar_mask = 3'b100;
      3'd6:    bar_mask = 3'b001;
      default: bar_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tpg_bar_lut.sv
// Colour bar lookup: bar index to full-scale {R,G,B} pixel.
module tpg_bar_lut
  import test_pattern_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [BAR_W-1:0]    bar_idx_i,
  output logic [3*DATA_W-1:0] rgb_c_o
);

  logic [2:0] mask_c;

  always_comb begin
    mask_c  = bar_mask(bar_idx_i);
    rgb_c_o = {{DATA_W{mask_c[2]}}, {DATA_W{mask_c[1]}}, {DATA_W{mask_c[0]}}};
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: re-times upstream sync by two cycles and
// fills active pixels with solid, colour bar, ramp or grid content.
module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          synci,
  input  logic [1:0]          pat_sel,
  input  logic [X_W-1:0]      h_size,
  input  logic [Y_W-1:0]      v_size,
  input  logic [3*DATA_W-1:0] solid_rgb,
  output logic [2:0]          synco,
  output logic [3*DATA_W-1:0] rgb,
  output logic                frame_start
);

  localparam int unsigned PIX_W = 3 * DATA_W;

  logic [PIPE_LAT-1:0][2:0] sync_pipe_q;
  logic [PIPE_LAT-1:0]      fs_pipe_q;
  logic [X_W-1:0]           x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic [X_W-1:0]           bar_cnt_q, bar_cnt_d;
  logic [BAR_W-1:0]         bar_idx_q, bar_idx_d;
  frame_cfg_t               cfg_q, cfg_d;
  logic [PIX_W-1:0]         solid_q, solid_d;
  logic [PIX_W-1:0]         rgb_s1_q, rgb_s1_d;
  logic [PIX_W-1:0]         rgb_q;

  logic                     de_c, vs_fall_c, de_fall_c, grid_on_c;
  logic [X_W-1:0]           bw_c;
  logic [DATA_W-1:0]        ramp_c;
  logic [PIX_W-1:0]         bar_rgb_c, pix_c;

  tpg_bar_lut #(.DATA_W(DATA_W)) u_bar_lut (
    .bar_idx_i (bar_idx_q),
    .rgb_c_o   (bar_rgb_c)
  );

  // Edge detection against the first sync pipeline stage (previous synci)
  always_comb begin
    de_c      = synci[0];
    vs_fall_c = sync_pipe_q[0][1] & ~synci[1];
    de_fall_c = sync_pipe_q[0][0] & ~synci[0];

    bw_c = {3'b000, cfg_q.h_size[X_W-1:3]};
    if (bw_c == '0) bw_c = X_W'(1);

    x_d       = '0;
    y_d       = y_q;
    bar_cnt_d = '0;
    bar_idx_d = '0;
    cfg_d     = cfg_q;
    solid_d   = solid_q;

    if (de_c) begin
      x_d = (x_q == '1) ? x_q : x_q + X_W'(1);
      if (bar_cnt_q == bw_c - X_W'(1)) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == '1) ? bar_idx_q : bar_idx_q + BAR_W'(1);
      end else begin
        bar_cnt_d = bar_cnt_q + X_W'(1);
        bar_idx_d = bar_idx_q;
      end
    end

    // A frame boundary clears y even when a line ends in the same cycle
    if (vs_fall_c) begin
      y_d          = '0;
      cfg_d.pat    = pattern_e'(pat_sel);
      cfg_d.h_size = h_size;
      cfg_d.v_size = v_size;
      solid_d      = solid_rgb;
    end else if (de_fall_c && (y_q != '1)) begin
      y_d = y_q + Y_W'(1);
    end

    grid_on_c = (x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0) ||
                (x_q == cfg_q.h_size - X_W'(1)) ||
                (y_q == cfg_q.v_size - Y_W'(1));
    ramp_c    = DATA_W'(x_q);

    pix_c = '0;
    case (cfg_q.pat)
      PAT_SOLID: pix_c = solid_q;
      PAT_BARS:  pix_c = bar_rgb_c;
      PAT_RAMP:  pix_c = {3{ramp_c}};
      default:   pix_c = grid_on_c ? '1 : '0;
    endcase

    rgb_s1_d = de_c ? pix_c : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe_q <= {PIPE_LAT{SYNCO_RST}};
      fs_pipe_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      cfg_q       <= '0;
      solid_q     <= '0;
      rgb_s1_q    <= '0;
      rgb_q       <= '0;
    end else begin
      sync_pipe_q <= {sync_pipe_q[PIPE_LAT-2:0], synci};
      fs_pipe_q   <= {fs_pipe_q[PIPE_LAT-2:0], vs_fall_c};
      x_q         <= x_d;
      y_q         <= y_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      cfg_q       <= cfg_d;
      solid_q     <= solid_d;
      rgb_s1_q    <= rgb_s1_d;
      rgb_q       <= rgb_s1_q;
    end
  end

  assign synco       = sync_pipe_q[PIPE_LAT-1];
  assign frame_start = fs_pipe_q[PIPE_LAT-1];
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: per-cycle reference tracking plus
// hand-computed spot checks of each pattern, frame latching and reset.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  synci;
  logic [1:0]  pat_sel;
  logic [11:0] h_size;
  logic [10:0] v_size;
  logic [23:0] solid_rgb;
  logic [2:0]  synco;
  logic [23:0] rgb;
  logic        frame_start;

  always #5 clk = ~clk;

  test_pattern_gen #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .synci       (synci),
    .pat_sel     (pat_sel),
    .h_size      (h_size),
    .v_size      (v_size),
    .solid_rgb   (solid_rgb),
    .synco       (synco),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  localparam logic [23:0] BAR [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the frame configuration the DUT should be using
  logic [1:0]  m_pat;
  logic [11:0] m_h;
  logic [10:0] m_v;
  logic [23:0] m_solid;
  logic        prev_vs;
  logic [2:0]  d1_sync;
  logic [23:0] d1_rgb;
  logic        d1_fs;
  int          d1_x, d1_y;
  logic [23:0] cap [0:1023];
  int          cap_line;
  int          fs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int x, input int y);
    int         bw, idx;
    logic [7:0] r;
    case (m_pat)
      2'd0: return m_solid;
      2'd1: begin
        bw = int'(m_h) >> 3;
        if (bw == 0) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        return BAR[idx];
      end
      2'd2: begin
        r = x[7:0];
        return {r, r, r};
      end
      default: return ((x % 32 == 0) || (y % 32 == 0) || (x == int'(m_h) - 1) ||
                       (y == int'(m_v) - 1)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_pat   = 2'd0;
    m_h     = '0;
    m_v     = '0;
    m_solid = '0;
    prev_vs = 1'b1;
    d1_sync = 3'b110;
    d1_rgb  = '0;
    d1_fs   = 1'b0;
    d1_x    = -1;
    d1_y    = -1;
  endtask

  // One clock of stimulus; outputs after the edge belong to the previous cycle's input
  task automatic step(input logic [2:0] s, input int x, input int y);
    logic        fs;
    logic [23:0] px;
    fs = prev_vs & ~s[1];
    px = s[0] ? exp_pix(x, y) : 24'h0;
    if (fs) begin
      m_pat   = pat_sel;
      m_h     = h_size;
      m_v     = v_size;
      m_solid = solid_rgb;
    end
    prev_vs = s[1];
    synci   = s;
    @(posedge clk);
    #1;
    chk("synco", 32'(synco), 32'(d1_sync));
    chk("rgb", 32'(rgb), 32'(d1_rgb));
    chk("frame_start", 32'(frame_start), 32'(d1_fs));
    if (frame_start) fs_cnt++;
    if (d1_sync[0] && d1_y == cap_line && d1_x >= 0 && d1_x < 1024) cap[d1_x] = rgb;
    d1_sync = s;
    d1_rgb  = px;
    d1_fs   = fs;
    d1_x    = x;
    d1_y    = y;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_synco", 32'(synco), 32'h6);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input int lines, input int hact, input bit do_vs,
                       input int chg_line, input logic [1:0] chg_pat, input int rst_line);
    fs_cnt = 0;
    for (int i = 0; i < 1024; i++) cap[i] = 24'hA5A5A5;
    if (do_vs) begin
      repeat (2) step(3'b110, -1, -1);
      repeat (3) step(3'b100, -1, -1);
      repeat (2) step(3'b110, -1, -1);
    end
    for (int l = 0; l < lines; l++) begin
      if (l == chg_line) pat_sel = chg_pat;
      repeat (2) step(3'b010, -1, -1);
      repeat (4) step(3'b110, -1, -1);
      for (int i = 0; i < hact; i++) begin
        if (l == rst_line && i == 5) do_reset();
        step(3'b111, i, l);
      end
    end
    repeat (3) step(3'b110, -1, -1);
    if (do_vs) chk("fs_per_frame", 32'(fs_cnt), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    synci     = 3'b110;
    pat_sel   = 2'd0;
    h_size    = '0;
    v_size    = '0;
    solid_rgb = '0;
    cap_line  = -1;
    fs_cnt    = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_synco", 32'(synco), 32'h6);
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_frame_start", 32'(frame_start), 32'h0);
    rst = 1'b0;

    // Inputs changed but no vsync yet: output stays black
    solid_rgb = 24'h123456;
    h_size    = 12'd16;
    v_size    = 11'd4;
    cap_line  = 1;
    frame(2, 16, 1'b0, -1, 2'd0, -1);
    chk("pre_vsync_black", 32'(cap[3]), 32'h0);

    cap_line = 1;
    frame(4, 16, 1'b1, -1, 2'd0, -1);
    chk("solid_x0", 32'(cap[0]), 32'h123456);
    chk("solid_x15", 32'(cap[15]), 32'h123456);

    pat_sel  = 2'd1;
    h_size   = 12'd640;
    v_size   = 11'd2;
    cap_line = 0;
    frame(2, 640, 1'b1, -1, 2'd0, -1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bar%0d_first", k), 32'(cap[80*k]), 32'(BAR[k]));
      chk($sformatf("bar%0d_last", k), 32'(cap[80*k+79]), 32'(BAR[k]));
    end

    pat_sel  = 2'd2;
    h_size   = 12'd300;
    cap_line = 1;
    frame(2, 300, 1'b1, -1, 2'd0, -1);
    chk("ramp_x0", 32'(cap[0]), 32'h000000);
    chk("ramp_x1", 32'(cap[1]), 32'h010101);
    chk("ramp_x255", 32'(cap[255]), 32'hFFFFFF);
    chk("ramp_x256", 32'(cap[256]), 32'h000000);
    chk("ramp_x299", 32'(cap[299]), 32'h2B2B2B);

    pat_sel  = 2'd3;
    h_size   = 12'd64;
    v_size   = 11'd48;
    cap_line = 5;
    frame(48, 64, 1'b1, -1, 2'd0, -1);
    chk("grid_y5_x0", 32'(cap[0]), 32'hFFFFFF);
    chk("grid_y5_x1", 32'(cap[1]), 32'h000000);
    chk("grid_y5_x31", 32'(cap[31]), 32'h000000);
    chk("grid_y5_x32", 32'(cap[32]), 32'hFFFFFF);
    chk("grid_y5_x62", 32'(cap[62]), 32'h000000);
    chk("grid_y5_x63", 32'(cap[63]), 32'hFFFFFF);
    cap_line = 32;
    frame(48, 64, 1'b1, -1, 2'd0, -1);
    chk("grid_y32_x7", 32'(cap[7]), 32'hFFFFFF);
    cap_line = 47;
    frame(48, 64, 1'b1, -1, 2'd0, -1);
    chk("grid_y47_x13", 32'(cap[13]), 32'hFFFFFF);

    // Pattern change mid-frame only takes effect after the next vsync
    pat_sel   = 2'd0;
    solid_rgb = 24'h123456;
    h_size    = 12'd16;
    v_size    = 11'd12;
    cap_line  = 11;
    frame(12, 16, 1'b1, 10, 2'd1, -1);
    chk("midframe_still_solid", 32'(cap[0]), 32'h123456);
    cap_line = 0;
    frame(2, 16, 1'b1, -1, 2'd0, -1);
    chk("next_frame_bar0", 32'(cap[0]), 32'hFFFFFF);
    chk("next_frame_bar1", 32'(cap[2]), 32'hFFFF00);
    chk("next_frame_bar7", 32'(cap[15]), 32'h000000);

    // Reset on line 100 aborts the frame; black until the next vsync
    pat_sel  = 2'd2;
    v_size   = 11'd200;
    cap_line = -1;
    frame(2, 16, 1'b1, -1, 2'd0, -1);
    cap_line = 101;
    frame(102, 16, 1'b1, -1, 2'd0, 100);
    chk("post_reset_black", 32'(cap[3]), 32'h0);
    cap_line = 0;
    frame(2, 16, 1'b1, -1, 2'd0, -1);
    chk("post_reset_ramp", 32'(cap[3]), 32'h030303);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
